// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider, valid/ready handshake.
// Define CORE_MULDIV_DIV_EN for full RV32M; leave undefined for a multiply-only (Zmmul) build.
module core_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            KILL,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic            I_MUL,
    input  logic            I_MULH,
    input  logic            I_MULHSU,
    input  logic            I_MULHU,
    input  logic            I_DIV,
    input  logic            I_DIVU,
    input  logic            I_REM,
    input  logic            I_REMU,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_NONE   = 4'd8
    } op_t;

`ifdef CORE_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
`endif

    state_t              r_state;
    state_t              w_state_next;
    op_t                 r_op;
    op_t                 w_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic                r_neg_res;
    logic [XLEN-1:0]     r_result;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_bypass;
    logic [XLEN-1:0]     w_bypass_val;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_calc_step;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_fix_result;

`ifdef CORE_MULDIV_DIV_EN
    logic                r_neg_rem;
    logic                w_r_is_div;
    logic                w_div_ovf;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
`endif

    // Fixed-priority op select; no select bit at all decodes to OP_NONE.
    always_comb begin
        w_op = OP_NONE;
        if (I_MUL)         w_op = OP_MUL;
        else if (I_MULH)   w_op = OP_MULH;
        else if (I_MULHSU) w_op = OP_MULHSU;
        else if (I_MULHU)  w_op = OP_MULHU;
        else if (I_DIV)    w_op = OP_DIV;
        else if (I_DIVU)   w_op = OP_DIVU;
        else if (I_REM)    w_op = OP_REM;
        else if (I_REMU)   w_op = OP_REMU;
    end

    always_comb begin
        w_is_div   = (w_op == OP_DIV) || (w_op == OP_DIVU) ||
                     (w_op == OP_REM) || (w_op == OP_REMU);
        w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_a_neg    = w_a_signed && RS1[XLEN-1];
        w_b_neg    = w_b_signed && RS2[XLEN-1];
        w_abs_a    = w_a_neg ? -RS1 : RS1;
        w_abs_b    = w_b_neg ? -RS2 : RS2;
    end

    // Ops that finish straight from IDLE without iterating.
    always_comb begin
        w_bypass     = 1'b0;
        w_bypass_val = '0;
`ifdef CORE_MULDIV_DIV_EN
        w_div_ovf    = (RS1 == MIN_VAL) && (RS2 == ALL_ONES);
`endif
        case (w_op)
            OP_NONE: w_bypass = 1'b1;
`ifdef CORE_MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (RS2 == '0) begin
                    w_bypass     = 1'b1;
                    w_bypass_val = ALL_ONES;
                end else if ((w_op == OP_DIV) && w_div_ovf) begin
                    w_bypass     = 1'b1;
                    w_bypass_val = MIN_VAL;
                end
            end
            OP_REM, OP_REMU: begin
                if (RS2 == '0) begin
                    w_bypass     = 1'b1;
                    w_bypass_val = RS1;
                end else if ((w_op == OP_REM) && w_div_ovf) begin
                    w_bypass     = 1'b1;
                    w_bypass_val = '0;
                end
            end
`else
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_bypass = 1'b1;
`endif
            default: ;
        endcase
    end

    // One iteration: upper half is partial product / remainder, lower half is multiplier / quotient.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
        w_calc_step = {w_mul_sum, r_acc[XLEN-1:1]};
`ifdef CORE_MULDIV_DIV_EN
        w_r_is_div  = (r_op == OP_DIV) || (r_op == OP_DIVU) ||
                      (r_op == OP_REM) || (r_op == OP_REMU);
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (w_r_is_div) begin
            if (w_div_diff[XLEN])
                w_calc_step = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_calc_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        w_prod_fix   = r_neg_res ? -r_acc : r_acc;
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
`ifdef CORE_MULDIV_DIV_EN
            OP_DIV, OP_DIVU:
                w_fix_result = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            OP_REM, OP_REMU:
                w_fix_result = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (IN_VALID && !KILL) begin
                    w_accept     = 1'b1;
                    w_state_next = w_bypass ? S_DONE : S_CALC;
                end
            end
            S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  if (OUT_READY) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (KILL) w_state_next = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_op        <= OP_NONE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_neg_res   <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
`ifdef CORE_MULDIV_DIV_EN
            r_neg_rem   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_cnt     <= CNT_W'(XLEN-1);
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                r_opb     <= w_is_div ? w_abs_b : w_abs_a;
`ifdef CORE_MULDIV_DIV_EN
                r_neg_rem <= w_a_neg;
`endif
                if (w_bypass) begin
                    r_result    <= w_bypass_val;
                    r_out_valid <= 1'b1;
                end
            end else if ((r_state == S_CALC) && !KILL) begin
                r_acc <= w_calc_step;
                r_cnt <= r_cnt - 1'b1;
            end else if ((r_state == S_FIX) && !KILL) begin
                r_result    <= w_fix_result;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_DONE) && OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            // Flush drops the result handshake but leaves RESULT holding its last value.
            if (KILL) r_out_valid <= 1'b0;
        end
    end

    assign IN_READY  = (r_state == S_IDLE);
    assign OUT_VALID = r_out_valid;
    assign RESULT    = r_result;

endmodule

// File: tb/tb_core_muldiv.sv
// Scoreboard bench for core_muldiv: directed vectors push expected results, a monitor pops on each handshake.
// Divide expectations follow CORE_MULDIV_DIV_EN (zero-result bypass when the divider is absent).
module tb_core_muldiv;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        KILL = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  sel = 8'h00;
    logic [31:0] RS1 = 32'h0;
    logic [31:0] RS2 = 32'h0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] RESULT;

`ifdef CORE_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [7:0] S_MUL = 8'h01, S_MULH = 8'h02, S_MULHSU = 8'h04, S_MULHU = 8'h08;
    localparam logic [7:0] S_DIV = 8'h10, S_DIVU = 8'h20, S_REM = 8'h40, S_REMU = 8'h80;

    core_muldiv #(.XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .KILL(KILL),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .I_MUL(sel[0]), .I_MULH(sel[1]), .I_MULHSU(sel[2]), .I_MULHU(sel[3]),
        .I_DIV(sel[4]), .I_DIVU(sel[5]), .I_REM(sel[6]), .I_REMU(sel[7]),
        .RS1(RS1), .RS2(RS2),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    typedef struct packed {
        logic [7:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
        logic        dv;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%08h expected no output", RESULT);
            end else begin
                check("result", RESULT, sb.pop_front());
            end
        end
    end

    task automatic add(input logic [7:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit dv);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.exp = exp; v.lat = 8'(lat); v.dv = dv;
        vecs.push_back(v);
    endtask

    // Drive one request, record its expectation, and count edges after accept until OUT_VALID.
    task automatic start_op(input string name, input logic [7:0] s, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        n = 0;
        while (!IN_READY && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        check({name, "_ready"}, {31'b0, IN_READY}, 32'd1);
        IN_VALID = 1'b1; sel = s; RS1 = a; RS2 = b;
        @(posedge CLK);
        sb.push_back(exp);
        #1;
        IN_VALID = 1'b0; sel = 8'h00;
        n = 0;
        while (!OUT_VALID && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        check({name, "_latency"}, 32'(n), 32'(lat));
    endtask

    task automatic finish_op(input string name);
        int n;
        n = 0;
        while (OUT_VALID && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        check({name, "_in_ready_after"}, {31'b0, IN_READY}, 32'd1);
    endtask

    task automatic quiet_window(input string name);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        check({name, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] e;
        int l;

        // Normal ops complete 33 edges after accept; bypassed ops are valid right after the accept edge.
        add(S_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        add(S_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 33, 1'b0);
        add(S_MULHU,  32'h80000000,  32'h80000000, 32'h40000000, 33, 1'b0);
        add(S_MULHSU, 32'h80000000,  32'h80000000, 32'hC0000000, 33, 1'b0);
        add(S_MULHSU, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 33, 1'b0);
        add(S_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 33, 1'b0);
        add(S_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        add(S_MUL | S_DIV, 32'd3,    32'd4,        32'd12,       33, 1'b0);
        add(8'h00,    32'd9,         32'd9,        32'd0,        0,  1'b0);
        add(S_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33, 1'b1);
        add(S_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33, 1'b1);
        add(S_DIVU,   32'd100,       32'd7,        32'd14,       33, 1'b1);
        add(S_REMU,   32'd100,       32'd7,        32'd2,        33, 1'b1);
        add(S_DIVU,   32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 33, 1'b1);
        add(S_DIV,    32'd5,         32'd0,        32'hFFFFFFFF, 0,  1'b1);
        add(S_REMU,   32'd5,         32'd0,        32'd5,        0,  1'b1);
        add(S_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 0,  1'b1);
        add(S_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        0,  1'b1);

        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_in_ready", {31'b0, IN_READY}, 32'd1);
        check("reset_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e = v.exp;
            l = int'(v.lat);
            if (v.dv && !DIV_EN) begin
                e = 32'd0;
                l = 0;
            end
            start_op($sformatf("vec%0d", i), v.s, v.a, v.b, e, l);
            finish_op($sformatf("vec%0d", i));
        end

        // Consumer stall: result must hold and no new accept is possible.
        OUT_READY = 1'b0;
        start_op("stall", S_MUL, 32'd3, 32'd5, 32'd15, 33);
        repeat (10) begin
            @(posedge CLK); #1;
            check("stall_result", RESULT, 32'd15);
            check("stall_in_ready", {31'b0, IN_READY}, 32'd0);
        end
        OUT_READY = 1'b1;
        finish_op("stall");

        // Kill during the fifth CALC cycle.
        IN_VALID = 1'b1; sel = S_MUL; RS1 = 32'd7; RS2 = 32'd9;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; sel = 8'h00;
        repeat (4) @(posedge CLK);
        #1;
        KILL = 1'b1;
        @(posedge CLK); #1;
        KILL = 1'b0;
        check("kill_calc_in_ready", {31'b0, IN_READY}, 32'd1);
        check("kill_calc_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("kill_calc_result_kept", RESULT, 32'd15);
        quiet_window("kill_calc");

        // Kill beats a simultaneous request in IDLE.
        KILL = 1'b1; IN_VALID = 1'b1; sel = S_MUL; RS1 = 32'd2; RS2 = 32'd2;
        @(posedge CLK); #1;
        KILL = 1'b0; IN_VALID = 1'b0; sel = 8'h00;
        check("kill_idle_in_ready", {31'b0, IN_READY}, 32'd1);
        quiet_window("kill_idle");

        // Reset in the middle of CALC.
        IN_VALID = 1'b1; sel = S_MULHU; RS1 = 32'hFFFFFFFF; RS2 = 32'hFFFFFFFF;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; sel = 8'h00;
        repeat (10) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_mid_result", RESULT, 32'd0);
        check("rst_mid_in_ready", {31'b0, IN_READY}, 32'd1);
        RST_N = 1'b1;
        quiet_window("rst_mid");

        start_op("post_reset_mul", S_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        finish_op("post_reset_mul");

        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
